reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Read-side companion to the processor register file: on a `start` pulse it walks a contiguous, wrapping window of registers through the file's combinational operand-read port. Each byte is emitted over a valid/ready stream with its register index and a last flag. It sits beside the register file for debug, scan-out and test. `busy` is used to stall the core so the file is not written mid-dump.

## Interface
- `pw`, default 4: register pointer width; the file holds 2**pw registers.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `base`  in  pw  first register index; sampled with `start`.
- `count`  in  pw+1  number of registers to dump; sampled with `start`; values above 2**pw clamp to 2**pw; 0 means an empty dump.
- `rd_addr`  out  pw  register-file read pointer (drives the operand-register address).
- `rd_data`  in  8  register-file read data (combinational from `rd_addr`).
- `out_valid`  out  1  stream byte valid.
- `out_ready`  in  1  consumer accepts the byte.
- `out_data`  out  8  captured register value.
- `out_addr`  out  pw  index of the register in `out_data`.
- `out_last`  out  1  high with the final byte of the dump.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of each dump, including empty dumps.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- Internal registers:
  - `addr_q` (pw bits): current register index.
  - `rem_q` (pw+1 bits): registers still to emit.
- IDLE:
  - On `start`: `addr_q`<=`base`, `rem_q`<=clamp(`count`).
  - Next state is LOAD if clamp(`count`)!=0, else DONE.
- LOAD:
  - `rd_addr`=`addr_q`.
  - At the clock edge: `out_data`<=`rd_data`, `out_addr`<=`addr_q`, `out_last`<=(`rem_q`==1); go to SEND.
- SEND:
  - `out_valid`=1.
  - If `out_ready` is low, hold: `out_data`, `out_addr`, `out_last` stay stable.
  - If `out_ready` is high and `out_last`=1, go to DONE.
  - If `out_ready` is high and `out_last`=0: `addr_q`<=`addr_q`+1 mod 2**pw, `rem_q`<=`rem_q`-1, go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- Address wrap: `base`=14, `count`=4 emits indices 14, 15, 0, 1.
- `rd_addr` equals `addr_q` in every state; nothing reads `rd_data` outside LOAD.
- The value emitted is the register contents during the LOAD cycle. Coherence relies on the core honouring `busy`.
- Reset in any state, including mid-SEND with `out_valid` high:
  - Next state is IDLE; the dump is abandoned.
  - All outputs return to reset values.
  - No `done` pulse is generated.

## Timing
- Reset values: `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` at edge T: `busy` high from T+1; LOAD during cycle T+1; `out_valid` high from T+2.
- With `out_ready` held high, each byte costs 2 cycles (LOAD + SEND).
  - N bytes: last acceptance at edge T+2N; `done` during cycle T+2N+1; IDLE at T+2N+2.
- Empty dump (`count`=0): DONE during cycle T+1, no `out_valid`, IDLE at T+2.
- Handshake: transfer occurs on an edge where `out_valid`&&`out_ready`. `out_valid` never drops without a transfer except on reset.
- `out_ready` has no combinational path to `out_valid` or `out_data`.

## Structure
- Shared package `regfile_pkg`: `REG_PW` constant (4), `REG_W` constant (8), `dump_state_t` enum {IDLE, LOAD, SEND, DONE}.
- Single module. The FSM, address counter and remaining counter are small, so no sub-module is warranted.

## Test plan
- Full dump: registers preloaded with r[i]=8'h10+i; `base`=0, `count`=16, `out_ready`=1 -> 16 bytes 8'h10..8'h1F, `out_addr` 0..15, `out_last` only on index 15, `done` at T+33.
- Wrap: `base`=14, `count`=4 -> `out_addr` 14, 15, 0, 1 with matching data; `out_last` on index 1.
- Backpressure: `out_ready` low for 5 cycles on the second byte -> data, addr and last held stable with `out_valid` high; byte sequence and count unchanged.
- Edge counts:
  - `count`=0 -> `done` at T+1, no `out_valid`.
  - `count`=20 -> exactly 16 bytes emitted.
  - `count`=1 -> a single byte with `out_last`=1.
- `start` re-pulsed while `busy` -> ignored; exactly one dump and one `done` pulse.
- Reset asserted while in SEND with `out_valid`=1 -> all outputs 0 next cycle, no `done`; a subsequent `start` performs a correct dump.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and dump FSM state type
package regfile_pkg;

  localparam int REG_PW = 4;
  localparam int REG_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks a wrapping register window out over a valid/ready byte stream
module reg_dump_reader
  import regfile_pkg::*;
#(
  parameter int pw = REG_PW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [pw-1:0]    base,
  input  logic [pw:0]      count,
  output logic [pw-1:0]    rd_addr,
  input  logic [REG_W-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_data,
  output logic [pw-1:0]    out_addr,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [pw:0] FULL_COUNT = {1'b1, {pw{1'b0}}};
  localparam logic [pw:0] REM_ONE    = (pw+1)'(1);

  dump_state_t      state_q, state_d;
  logic [pw-1:0]    addr_q, addr_d;
  logic [pw:0]      rem_q, rem_d;
  logic [REG_W-1:0] out_data_q, out_data_d;
  logic [pw-1:0]    out_addr_q, out_addr_d;
  logic             out_last_q, out_last_d;
  logic [pw:0]      count_clamped;

  assign count_clamped = (count > FULL_COUNT) ? FULL_COUNT : count;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base;
          rem_d   = count_clamped;
          state_d = (count_clamped != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        // rd_data is combinational from rd_addr == addr_q, so it is captured here only
        out_data_d = rd_data;
        out_addr_d = addr_q;
        out_last_d = (rem_q == REM_ONE);
        state_d    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + pw'(1);
            rem_d   = rem_q - REM_ONE;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      out_last_q <= out_last_d;
    end
  end

  assign rd_addr   = addr_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized bench for reg_dump_reader against a queue-based dump model
module tb_reg_dump_reader;

  localparam int PW   = 4;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [PW-1:0]   base;
  logic [PW:0]     count;
  logic [PW-1:0]   rd_addr;
  logic [7:0]      rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic [PW-1:0]   out_addr;
  logic            out_last;
  logic            busy;
  logic            done;

  logic [7:0] regs [NREG];

  typedef struct {
    logic [PW-1:0] a;
    logic [7:0]    d;
    logic          l;
  } beat_t;

  beat_t exp_q [$];
  int checks = 0;
  int errors = 0;

  reg_dump_reader #(.pw(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
  endtask

  // mode 0: ready always high (timing checked), 1: random ready, 2: 5-cycle stall on second byte
  task automatic run_dump(input logic [PW-1:0] b, input logic [PW:0] c, input int mode, input bit repulse);
    int n;
    int k;
    int got_bytes;
    int dones;
    int stall;
    bit finished;
    bit prev_hold;
    logic [7:0] pd;
    logic [PW-1:0] pa;
    logic pl;
    beat_t bt;
    n = (int'(c) > NREG) ? NREG : int'(c);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bt.a = PW'((int'(b) + i) % NREG);
      bt.d = regs[bt.a];
      bt.l = (i == n - 1);
      exp_q.push_back(bt);
    end
    @(negedge clk);
    base = b; count = c; start = 1'b1; out_ready = 1'b0;
    k = 0; got_bytes = 0; dones = 0; stall = 0; finished = 0; prev_hold = 0;
    pd = '0; pa = '0; pl = 1'b0;
    while (!finished && k < 300) begin
      @(negedge clk);
      k++;
      start = (repulse && (k == 3 || k == 6)) ? 1'b1 : 1'b0;
      if (repulse) base = ~b;
      if (k == 1) check_eq("busy_after_start", busy, 1);
      if (prev_hold) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, pd);
        check_eq("hold_addr", out_addr, pa);
        check_eq("hold_last", out_last, pl);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(got_bytes == 1 && stall < 5);
      endcase
      if (mode == 2 && out_valid && !out_ready) stall++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", out_valid, 0);
        end else if (out_ready) begin
          bt = exp_q.pop_front();
          check_eq("byte_data", out_data, bt.d);
          check_eq("byte_addr", out_addr, bt.a);
          check_eq("byte_last", out_last, bt.l);
          got_bytes++;
          if (mode == 0) check_eq("byte_timing", k, 2 * got_bytes);
        end
        prev_hold = !out_ready;
        pd = out_data; pa = out_addr; pl = out_last;
      end else begin
        prev_hold = 0;
      end
      if (done) begin
        dones++;
        check_eq("done_no_valid", out_valid, 0);
        if (mode == 0) check_eq("done_timing", k, 2 * n + 1);
      end else if (dones > 0) begin
        finished = 1;
        check_eq("idle_busy", busy, 0);
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
    check_eq("dump_timeout", finished, 1);
    check_eq("byte_count", got_bytes, n);
    check_eq("done_count", dones, 1);
    if (mode == 2 && n >= 2) check_eq("stall_cycles", stall, 5);
    repeat (2) begin
      @(negedge clk);
      check_eq("stays_idle", {busy, done, out_valid}, 3'b000);
    end
  endtask

  task automatic reset_mid_send();
    int k;
    fill_random();
    @(negedge clk);
    base = 4'd3; count = 5'd5; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("reset_reach_send", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    check_eq("post_rst_no_done", {done, busy}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) regs[i] = 8'h10 + 8'(i);
    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_out_addr", out_addr, 0);
    check_eq("reset_out_last", out_last, 0);
    check_eq("reset_rd_addr", rd_addr, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    reset = 1'b0;

    run_dump(4'd0, 5'd16, 0, 1'b0);
    fill_random();
    run_dump(4'd14, 5'd4, 0, 1'b0);
    run_dump(4'd2, 5'd6, 2, 1'b0);
    run_dump(4'd7, 5'd0, 0, 1'b0);
    run_dump(4'd9, 5'd20, 0, 1'b0);
    run_dump(4'd11, 5'd1, 0, 1'b0);
    run_dump(4'd5, 5'd8, 0, 1'b1);
    reset_mid_send();
    run_dump(4'd3, 5'd5, 0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      fill_random();
      run_dump(PW'($urandom), 5'($urandom_range(0, 31)), 1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
